inst_fetcher: RTL and testbench
===============================

# inst_fetcher

Instruction fetch stage of the out-of-order RISC-V core. It walks the PC, requests 32-bit words from the instruction cache, and pre-decodes branch/JAL. It queries the two-level branch predictor for conditional branches and hands each instruction, tagged with its prediction, to the decoder. It also buffers committed branch outcomes from the ROB and replays them to the predictor on its feedback port in cycles when no prediction is requested, since the predictor cannot serve both in one cycle.

## Interface
- ADDR_WIDTH, 32, PC width
- RESET_PC, 32'h0, first fetch address
- FB_DEPTH, 4, feedback queue entries (power of 2)

- Sys_clk  in  1  clock, rising edge
- Sys_rst  in  1  reset, asynchronous, active-low
- Sys_rdy  in  1  global enable; low freezes all state
- IFIC_en  out  1  fetch request, held until ICIF_ready
- IFIC_pc  out  ADDR_WIDTH  fetch address, stable while IFIC_en
- ICIF_ready  in  1  one-cycle pulse: ICIF_inst valid
- ICIF_inst  in  32  fetched word
- IFPD_predict_en  out  1  prediction request (combinational)
- IFPD_pc  out  ADDR_WIDTH  branch PC (= IFIC_pc)
- PDIF_predict_result  in  1  1 = taken, valid same cycle
- IFPD_feedback_en  out  1  feedback strobe
- IFPD_branch_result  out  1  resolved direction
- IFPD_feedback_pc  out  ADDR_WIDTH  resolved branch PC
- ROBIF_branch_en  in  1  ROB commits a conditional branch
- ROBIF_branch_result  in  1  its direction
- ROBIF_branch_pc  in  ADDR_WIDTH  its PC
- IFROB_fb_full  out  1  feedback queue full; ROB holds commits
- ROBIF_jump_wrong  in  1  misprediction, redirect
- ROBIF_jump_pc  in  ADDR_WIDTH  correct PC
- DCIF_full  in  1  decoder cannot accept
- IFDC_en  out  1  instruction valid, one-cycle pulse
- IFDC_inst  out  32  instruction
- IFDC_pc  out  ADDR_WIDTH  its PC
- IFDC_predict  out  1  1 = fetch followed taken path

## Operation
- States: FLUSH, FETCH, HOLD. Reset -> FLUSH with pc=RESET_PC.
- FLUSH: IFIC_en=0 for exactly one cycle, then FETCH.
- FETCH: IFIC_en=1, IFIC_pc=pc. On ICIF_ready, pre-decode opcode ICIF_inst[6:0]:
  - 1100011 branch: IFPD_predict_en=1 this cycle. next_pc = PDIF_predict_result ? pc+immB : pc+4. pred=PDIF_predict_result.
  - 1101111 JAL: next_pc=pc+immJ, pred=1, no predictor query.
  - Others, including JALR: next_pc=pc+4, pred=0.
  - immB={{19{i[31]}},i[31],i[7],i[30:25],i[11:8],1'b0}; immJ={{11{i[31]}},i[31],i[19:12],i[20],i[30:21],1'b0}. Sum is mod 2^ADDR_WIDTH; wrap is silent.
  - DCIF_full=0: register inst/pc/pred to IFDC_*, pc<=next_pc, stay in FETCH.
  - DCIF_full=1: latch into hold regs, pc<=next_pc, go to HOLD.
- HOLD: IFIC_en=0. When DCIF_full=0, emit held instruction and go to FETCH.
- Redirect: ROBIF_jump_wrong has top priority in every state. pc<=ROBIF_jump_pc, go to FLUSH. Any same-cycle ICIF_ready word and any held instruction are discarded. IFDC_en=0 and IFPD_predict_en=0 that cycle.
- Feedback queue (FB_DEPTH FIFO of {result, pc}):
  - Push on ROBIF_branch_en when count<FB_DEPTH. A push when full is dropped, even if a pop occurs in the same cycle.
  - IFROB_fb_full = (count==FB_DEPTH).
  - Pop when count>0, IFPD_predict_en=0 and Sys_rdy=1. IFPD_feedback_en=1 that cycle, with the head driven combinationally on IFPD_branch_result/IFPD_feedback_pc.
  - Redirect does not flush the queue.
- Sys_rdy=0: no state change. IFPD_predict_en, IFPD_feedback_en and IFDC_en are forced 0; ICIF_ready is ignored.

## Timing
- Reset values: IFIC_en=0, IFIC_pc=RESET_PC, IFDC_en=0, IFDC_inst=0, IFDC_pc=0, IFDC_predict=0, IFPD_predict_en=0, IFPD_feedback_en=0, queue empty, IFROB_fb_full=0.
- Reset asserted mid-fetch aborts immediately; the request is not reissued until one FLUSH cycle after release.
- IFDC_en rises the cycle after ICIF_ready (FETCH) or after DCIF_full falls (HOLD).
- Back-to-back fetch: IFIC_en is high with the new pc in the cycle after ICIF_ready.
- Redirect: first request to ROBIF_jump_pc appears 2 cycles after ROBIF_jump_wrong.
- Feedback latency: at least 1 cycle from push to IFPD_feedback_en. Queue-empty push is not bypassed.

## Configuration
- BRANCH_PREDICT_EN defined: behaviour as above.
- BRANCH_PREDICT_EN undefined: all branches predicted not-taken (pred=0, next_pc=pc+4), IFPD_predict_en and IFPD_feedback_en tied 0, queue removed, IFROB_fb_full tied 0. JAL still follows immJ.

## Test plan
- Reset release, icache returns ADDI at pc 0 -> IFIC_pc 0, then 4. IFDC_en pulse with IFDC_pc=0, IFDC_predict=0.
- BEQ at 0x10 with immB=-8 (i=32'hFE000CE3), PDIF_predict_result=1 -> IFPD_predict_en=1 with IFPD_pc=0x10 that cycle. Next IFIC_pc=0x08, IFDC_predict=1.
- DCIF_full=1 when word arrives -> HOLD, IFIC_en=0, no IFDC_en. DCIF_full drops -> IFDC_en next cycle, then fetch resumes.
- ROBIF_jump_wrong with ROBIF_jump_pc=0x200 in the same cycle as ICIF_ready -> word discarded, IFIC_en=0 one cycle, then IFIC_pc=0x200.
- 5 ROBIF_branch_en commits while predictions occur every fetch -> fb_full after 4, 5th dropped, entries drain in FIFO order only in non-predict cycles.
- Sys_rdy=0 for 3 cycles mid-FETCH -> IFIC_pc, queue and state unchanged, and all strobes 0.

Source files
------------

// File: rtl/inst_fetcher.sv
// inst_fetcher: instruction fetch stage.
//
// Walks the PC and requests 32-bit words from the icache. Branches and JAL are pre-decoded
// to pick the next PC. Fetched words are passed to the decoder, tagged with the prediction.
// If the decoder is full, one word is parked in hold registers.
// Committed branch outcomes from the ROB are queued and replayed to the predictor. Replay
// only happens in cycles where no prediction is requested.
//
// Optional feature macro: BRANCH_PREDICT_EN. When it is undefined:
//   - every branch is predicted not-taken;
//   - the predictor ports and the feedback queue are inert.
//
// Ports:
//   Sys_clk, Sys_rst (async, active-low), Sys_rdy (global enable)
//   IFIC_*  : icache request (en/pc); ICIF_* : icache response (ready/inst)
//   IFPD_* / PDIF_* : predictor query and feedback replay
//   ROBIF_branch_* / IFROB_fb_full : committed branch outcomes into the feedback queue
//   ROBIF_jump_* : misprediction redirect
//   DCIF_full / IFDC_* : decoder handshake and instruction output
module inst_fetcher #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
  parameter int unsigned            FB_DEPTH   = 4
) (
  input  logic                  Sys_clk,
  input  logic                  Sys_rst,
  input  logic                  Sys_rdy,
  output logic                  IFIC_en,
  output logic [ADDR_WIDTH-1:0] IFIC_pc,
  input  logic                  ICIF_ready,
  input  logic [31:0]           ICIF_inst,
  output logic                  IFPD_predict_en,
  output logic [ADDR_WIDTH-1:0] IFPD_pc,
  input  logic                  PDIF_predict_result,
  output logic                  IFPD_feedback_en,
  output logic                  IFPD_branch_result,
  output logic [ADDR_WIDTH-1:0] IFPD_feedback_pc,
  input  logic                  ROBIF_branch_en,
  input  logic                  ROBIF_branch_result,
  input  logic [ADDR_WIDTH-1:0] ROBIF_branch_pc,
  output logic                  IFROB_fb_full,
  input  logic                  ROBIF_jump_wrong,
  input  logic [ADDR_WIDTH-1:0] ROBIF_jump_pc,
  input  logic                  DCIF_full,
  output logic                  IFDC_en,
  output logic [31:0]           IFDC_inst,
  output logic [ADDR_WIDTH-1:0] IFDC_pc,
  output logic                  IFDC_predict
);

  typedef enum logic [1:0] {StFlush, StFetch, StHold} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  dc_en_q, dc_en_d;
  logic [31:0]           dc_inst_q, dc_inst_d;
  logic [ADDR_WIDTH-1:0] dc_pc_q, dc_pc_d;
  logic                  dc_pred_q, dc_pred_d;
  logic [31:0]           hold_inst_q, hold_inst_d;
  logic [ADDR_WIDTH-1:0] hold_pc_q, hold_pc_d;
  logic                  hold_pred_q, hold_pred_d;

  logic                  fire;
  logic                  is_branch, is_jal, take_branch, pred;
  logic [31:0]           imm_b, imm_j;
  logic [ADDR_WIDTH-1:0] next_pc;

  // A word is consumed only when enabled, requested, and not being squashed by a redirect.
  assign fire = (state_q == StFetch) && ICIF_ready && Sys_rdy && !ROBIF_jump_wrong;

  assign is_branch = (ICIF_inst[6:0] == 7'b1100011);
  assign is_jal    = (ICIF_inst[6:0] == 7'b1101111);
  assign imm_b = {{19{ICIF_inst[31]}}, ICIF_inst[31], ICIF_inst[7], ICIF_inst[30:25],
                  ICIF_inst[11:8], 1'b0};
  assign imm_j = {{11{ICIF_inst[31]}}, ICIF_inst[31], ICIF_inst[19:12], ICIF_inst[20],
                  ICIF_inst[30:21], 1'b0};

`ifdef BRANCH_PREDICT_EN
  assign IFPD_predict_en = fire && is_branch;
  assign take_branch     = IFPD_predict_en && PDIF_predict_result;
`else
  assign IFPD_predict_en = 1'b0;
  assign take_branch     = 1'b0;
`endif

  assign pred = is_jal || take_branch;

  always_comb begin
    if (is_jal) begin
      next_pc = pc_q + ADDR_WIDTH'($signed(imm_j));
    end else if (take_branch) begin
      next_pc = pc_q + ADDR_WIDTH'($signed(imm_b));
    end else begin
      next_pc = pc_q + ADDR_WIDTH'(4);
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    dc_en_d     = 1'b0;
    dc_inst_d   = dc_inst_q;
    dc_pc_d     = dc_pc_q;
    dc_pred_d   = dc_pred_q;
    hold_inst_d = hold_inst_q;
    hold_pc_d   = hold_pc_q;
    hold_pred_d = hold_pred_q;
    if (ROBIF_jump_wrong) begin
      // Any in-flight or held word is younger than the mispredicted branch: drop it.
      state_d = StFlush;
      pc_d    = ROBIF_jump_pc;
    end else begin
      case (state_q)
        StFlush: state_d = StFetch;
        StFetch: begin
          if (fire) begin
            pc_d = next_pc;
            if (!DCIF_full) begin
              dc_en_d   = 1'b1;
              dc_inst_d = ICIF_inst;
              dc_pc_d   = pc_q;
              dc_pred_d = pred;
            end else begin
              hold_inst_d = ICIF_inst;
              hold_pc_d   = pc_q;
              hold_pred_d = pred;
              state_d     = StHold;
            end
          end
        end
        StHold: begin
          if (!DCIF_full) begin
            dc_en_d   = 1'b1;
            dc_inst_d = hold_inst_q;
            dc_pc_d   = hold_pc_q;
            dc_pred_d = hold_pred_q;
            state_d   = StFetch;
          end
        end
        default: state_d = StFlush;
      endcase
    end
  end

  always_ff @(posedge Sys_clk or negedge Sys_rst) begin
    if (!Sys_rst) begin
      state_q     <= StFlush;
      pc_q        <= RESET_PC;
      dc_en_q     <= 1'b0;
      dc_inst_q   <= '0;
      dc_pc_q     <= '0;
      dc_pred_q   <= 1'b0;
      hold_inst_q <= '0;
      hold_pc_q   <= '0;
      hold_pred_q <= 1'b0;
    end else if (Sys_rdy) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      dc_en_q     <= dc_en_d;
      dc_inst_q   <= dc_inst_d;
      dc_pc_q     <= dc_pc_d;
      dc_pred_q   <= dc_pred_d;
      hold_inst_q <= hold_inst_d;
      hold_pc_q   <= hold_pc_d;
      hold_pred_q <= hold_pred_d;
    end
  end

  assign IFIC_en      = (state_q == StFetch);
  assign IFIC_pc      = pc_q;
  assign IFPD_pc      = pc_q;
  // dc_en_q survives a freeze, so masking here delivers the word exactly once afterwards.
  assign IFDC_en      = dc_en_q && Sys_rdy && !ROBIF_jump_wrong;
  assign IFDC_inst    = dc_inst_q;
  assign IFDC_pc      = dc_pc_q;
  assign IFDC_predict = dc_pred_q;

`ifdef BRANCH_PREDICT_EN
  localparam int unsigned PtrW = (FB_DEPTH > 1) ? $clog2(FB_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDR_WIDTH-1:0] fb_pc_q  [FB_DEPTH];
  logic                  fb_res_q [FB_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;
  logic                  push, pop;

  assign IFROB_fb_full = (count_q == CntW'(FB_DEPTH));
  // Full is judged before any same-cycle pop, so a push into a full queue is lost.
  assign push = Sys_rdy && ROBIF_branch_en && !IFROB_fb_full;
  assign pop  = Sys_rdy && (count_q != '0) && !IFPD_predict_en;

  assign IFPD_feedback_en   = pop;
  assign IFPD_branch_result = fb_res_q[rd_ptr_q];
  assign IFPD_feedback_pc   = fb_pc_q[rd_ptr_q];

  always_ff @(posedge Sys_clk or negedge Sys_rst) begin
    if (!Sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge Sys_clk) begin
    if (push) begin
      fb_pc_q[wr_ptr_q]  <= ROBIF_branch_pc;
      fb_res_q[wr_ptr_q] <= ROBIF_branch_result;
    end
  end
`else
  logic unused_fb;

  assign IFPD_feedback_en   = 1'b0;
  assign IFPD_branch_result = 1'b0;
  assign IFPD_feedback_pc   = '0;
  assign IFROB_fb_full      = 1'b0;
  assign unused_fb = ^{ROBIF_branch_en, ROBIF_branch_result, ROBIF_branch_pc,
                       PDIF_predict_result};
`endif

endmodule

// File: tb/tb_inst_fetcher.sv
module tb_inst_fetcher;

`ifdef BRANCH_PREDICT_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] BEQ  = 32'hFE000CE3;  // immB = -8
  localparam logic [31:0] JAL  = 32'h1000006F;  // immJ = +0x100

  logic        Sys_clk = 1'b0;
  logic        Sys_rst, Sys_rdy;
  logic        IFIC_en;
  logic [31:0] IFIC_pc;
  logic        ICIF_ready;
  logic [31:0] ICIF_inst;
  logic        IFPD_predict_en;
  logic [31:0] IFPD_pc;
  logic        PDIF_predict_result;
  logic        IFPD_feedback_en, IFPD_branch_result;
  logic [31:0] IFPD_feedback_pc;
  logic        ROBIF_branch_en, ROBIF_branch_result;
  logic [31:0] ROBIF_branch_pc;
  logic        IFROB_fb_full;
  logic        ROBIF_jump_wrong;
  logic [31:0] ROBIF_jump_pc;
  logic        DCIF_full;
  logic        IFDC_en;
  logic [31:0] IFDC_inst, IFDC_pc;
  logic        IFDC_predict;

  inst_fetcher #(
    .ADDR_WIDTH(32),
    .RESET_PC  (32'h0),
    .FB_DEPTH  (4)
  ) dut (
    .Sys_clk            (Sys_clk),
    .Sys_rst            (Sys_rst),
    .Sys_rdy            (Sys_rdy),
    .IFIC_en            (IFIC_en),
    .IFIC_pc            (IFIC_pc),
    .ICIF_ready         (ICIF_ready),
    .ICIF_inst          (ICIF_inst),
    .IFPD_predict_en    (IFPD_predict_en),
    .IFPD_pc            (IFPD_pc),
    .PDIF_predict_result(PDIF_predict_result),
    .IFPD_feedback_en   (IFPD_feedback_en),
    .IFPD_branch_result (IFPD_branch_result),
    .IFPD_feedback_pc   (IFPD_feedback_pc),
    .ROBIF_branch_en    (ROBIF_branch_en),
    .ROBIF_branch_result(ROBIF_branch_result),
    .ROBIF_branch_pc    (ROBIF_branch_pc),
    .IFROB_fb_full      (IFROB_fb_full),
    .ROBIF_jump_wrong   (ROBIF_jump_wrong),
    .ROBIF_jump_pc      (ROBIF_jump_pc),
    .DCIF_full          (DCIF_full),
    .IFDC_en            (IFDC_en),
    .IFDC_inst          (IFDC_inst),
    .IFDC_pc            (IFDC_pc),
    .IFDC_predict       (IFDC_predict)
  );

  always #5 Sys_clk = ~Sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge Sys_clk);
    #1;
  endtask

  logic [31:0] p;

  initial begin
    Sys_rst = 1'b0; Sys_rdy = 1'b1;
    ICIF_ready = 1'b0; ICIF_inst = '0; PDIF_predict_result = 1'b0;
    ROBIF_branch_en = 1'b0; ROBIF_branch_result = 1'b0; ROBIF_branch_pc = '0;
    ROBIF_jump_wrong = 1'b0; ROBIF_jump_pc = '0; DCIF_full = 1'b0;
    tick(); tick();

    // Reset state
    check_eq("rst_ific_en", IFIC_en, 0);
    check_eq("rst_ific_pc", IFIC_pc, 32'h0);
    check_eq("rst_ifdc_en", IFDC_en, 0);
    check_eq("rst_ifdc_inst", IFDC_inst, 0);
    check_eq("rst_ifdc_pc", IFDC_pc, 0);
    check_eq("rst_ifdc_pred", IFDC_predict, 0);
    check_eq("rst_predict_en", IFPD_predict_en, 0);
    check_eq("rst_fb_en", IFPD_feedback_en, 0);
    check_eq("rst_fb_full", IFROB_fb_full, 0);

    // Release: one FLUSH cycle, then fetch at 0
    Sys_rst = 1'b1;
    #1 check_eq("flush_ific_en", IFIC_en, 0);
    tick();
    check_eq("fetch0_en", IFIC_en, 1);
    check_eq("fetch0_pc", IFIC_pc, 32'h0);

    // ADDI at 0
    ICIF_ready = 1'b1; ICIF_inst = ADDI;
    #1 check_eq("addi_no_predict", IFPD_predict_en, 0);
    tick(); ICIF_ready = 1'b0;
    check_eq("b2b_en", IFIC_en, 1);
    check_eq("b2b_pc", IFIC_pc, 32'h4);
    check_eq("addi_dc_en", IFDC_en, 1);
    check_eq("addi_dc_pc", IFDC_pc, 32'h0);
    check_eq("addi_dc_inst", IFDC_inst, ADDI);
    check_eq("addi_dc_pred", IFDC_predict, 0);
    tick();
    check_eq("dc_en_pulse", IFDC_en, 0);

    // Three NOPs back to back to reach 0x10
    for (int i = 0; i < 3; i++) begin
      ICIF_ready = 1'b1; ICIF_inst = NOP;
      tick();
    end
    ICIF_ready = 1'b0;
    check_eq("pc_at_10", IFIC_pc, 32'h10);

    // BEQ at 0x10, predicted taken
    ICIF_ready = 1'b1; ICIF_inst = BEQ; PDIF_predict_result = 1'b1;
    #1;
    check_eq("beq_predict_en", IFPD_predict_en, BP);
    check_eq("beq_ifpd_pc", IFPD_pc, 32'h10);
    tick(); ICIF_ready = 1'b0; PDIF_predict_result = 1'b0;
    p = BP ? 32'h08 : 32'h14;
    check_eq("beq_next_pc", IFIC_pc, p);
    check_eq("beq_dc_pc", IFDC_pc, 32'h10);
    check_eq("beq_dc_pred", IFDC_predict, BP);

    // JAL +0x100
    ICIF_ready = 1'b1; ICIF_inst = JAL;
    #1 check_eq("jal_no_predict", IFPD_predict_en, 0);
    tick();
    check_eq("jal_next_pc", IFIC_pc, p + 32'h100);
    check_eq("jal_dc_pred", IFDC_predict, 1);
    check_eq("jal_dc_en", IFDC_en, 1);
    p = p + 32'h100;

    // Decoder full: word goes to HOLD
    ICIF_ready = 1'b1; ICIF_inst = ADDI; DCIF_full = 1'b1;
    tick(); ICIF_ready = 1'b0;
    check_eq("hold_ific_en", IFIC_en, 0);
    check_eq("hold_dc_en", IFDC_en, 0);
    tick();
    check_eq("hold2_ific_en", IFIC_en, 0);
    check_eq("hold2_dc_en", IFDC_en, 0);
    DCIF_full = 1'b0;
    tick();
    check_eq("unhold_dc_en", IFDC_en, 1);
    check_eq("unhold_dc_pc", IFDC_pc, p);
    check_eq("unhold_dc_inst", IFDC_inst, ADDI);
    check_eq("unhold_ific_en", IFIC_en, 1);
    check_eq("unhold_ific_pc", IFIC_pc, p + 32'h4);
    tick();
    check_eq("unhold_pulse", IFDC_en, 0);

    // Redirect coinciding with an icache word
    ICIF_ready = 1'b1; ICIF_inst = BEQ; PDIF_predict_result = 1'b1;
    ROBIF_jump_wrong = 1'b1; ROBIF_jump_pc = 32'h200;
    #1 check_eq("redir_no_predict", IFPD_predict_en, 0);
    tick();
    ICIF_ready = 1'b0; PDIF_predict_result = 1'b0; ROBIF_jump_wrong = 1'b0;
    check_eq("redir_flush_en", IFIC_en, 0);
    check_eq("redir_discard", IFDC_en, 0);
    tick();
    check_eq("redir_ific_en", IFIC_en, 1);
    check_eq("redir_ific_pc", IFIC_pc, 32'h200);
    check_eq("redir_no_dc", IFDC_en, 0);

    // Five commits while every cycle carries a prediction
    for (int i = 0; i < 5; i++) begin
      ICIF_ready = 1'b1; ICIF_inst = BEQ;
      ROBIF_branch_en = 1'b1;
      ROBIF_branch_pc = 32'hA0 + 32'(4 * i);
      ROBIF_branch_result = (i % 2 == 0);
      #1 check_eq("fb_blocked_by_predict", IFPD_feedback_en, 0);
      tick();
      if (i >= 3) check_eq("fb_full", IFROB_fb_full, BP);
    end
    ICIF_ready = 1'b0; ROBIF_branch_en = 1'b0;
    #1;
    check_eq("fb0_en", IFPD_feedback_en, BP);
    check_eq("fb0_pc", IFPD_feedback_pc, BP ? 32'hA0 : 32'h0);
    check_eq("fb0_res", IFPD_branch_result, BP);
    tick();
    check_eq("fb_not_full", IFROB_fb_full, 0);
    ICIF_ready = 1'b1; ICIF_inst = BEQ;
    #1 check_eq("fb_wait_predict", IFPD_feedback_en, 0);
    tick(); ICIF_ready = 1'b0;
    for (int k = 1; k < 4; k++) begin
      #1;
      check_eq("fbk_en", IFPD_feedback_en, BP);
      check_eq("fbk_pc", IFPD_feedback_pc, BP ? 32'hA0 + 32'(4 * k) : 32'h0);
      check_eq("fbk_res", IFPD_branch_result, BP ? 32'(k % 2 == 0) : 32'h0);
      tick();
    end
    #1 check_eq("fb_fifth_dropped", IFPD_feedback_en, 0);
    check_eq("pc_after_fb", IFIC_pc, 32'h218);

    // Freeze with a pending decoder pulse and a queued feedback entry
    ICIF_ready = 1'b1; ICIF_inst = ADDI;
    ROBIF_branch_en = 1'b1; ROBIF_branch_pc = 32'hC0; ROBIF_branch_result = 1'b1;
    tick();
    ROBIF_branch_en = 1'b0;
    Sys_rdy = 1'b0; ICIF_inst = BEQ; PDIF_predict_result = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("frz_dc_en", IFDC_en, 0);
      check_eq("frz_predict_en", IFPD_predict_en, 0);
      check_eq("frz_fb_en", IFPD_feedback_en, 0);
      check_eq("frz_pc", IFIC_pc, 32'h21C);
      tick();
    end
    Sys_rdy = 1'b1; ICIF_ready = 1'b0; PDIF_predict_result = 1'b0;
    #1;
    check_eq("thaw_dc_en", IFDC_en, 1);
    check_eq("thaw_dc_pc", IFDC_pc, 32'h218);
    check_eq("thaw_fb_en", IFPD_feedback_en, BP);
    check_eq("thaw_fb_pc", IFPD_feedback_pc, BP ? 32'hC0 : 32'h0);
    check_eq("thaw_ific_en", IFIC_en, 1);
    check_eq("thaw_ific_pc", IFIC_pc, 32'h21C);
    tick();
    check_eq("thaw_dc_pulse", IFDC_en, 0);
    check_eq("thaw_fb_pulse", IFPD_feedback_en, 0);

    // Reset asserted mid-fetch aborts at once
    Sys_rst = 1'b0;
    #1;
    check_eq("async_rst_en", IFIC_en, 0);
    check_eq("async_rst_pc", IFIC_pc, 32'h0);
    tick();
    Sys_rst = 1'b1;
    #1 check_eq("rst_flush_en", IFIC_en, 0);
    tick();
    check_eq("rst_refetch_en", IFIC_en, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
